// File: rtl/zpaq_fxa_axi_slave_mem.sv
// AXI4 burst slave over a 2**MEM_AW x 32 RAM: W one beat/cycle, B one cycle after the last W, R first beat two edges after AR then one per two cycles.
// Independent W and R FSMs stall on VALID/READY; define ZPAQ_AXI_SLV_RANGE_CHK_EN to reject beats at or above the RAM size with SLVERR.
module zpaq_fxa_axi_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_AW             = 10
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int DEPTH = 2 ** MEM_AW;
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] BEAT = 4;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  logic                          ready_en;
  logic [C_S_AXI_ID_WIDTH-1:0]   w_id, r_id;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_addr, r_addr;
  logic [7:0]                    w_len, w_cnt, r_len, r_cnt;
  logic                          w_fixed, r_fixed, w_err;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                    r_resp;
  logic                          r_last;

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic w_at_len, w_last_beat, w_mismatch, r_at_len;
  logic w_oob, r_oob;
  logic unused_ok;

  assign unused_ok = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

`ifdef ZPAQ_AXI_SLV_RANGE_CHK_EN
  assign w_oob = |w_addr[C_S_AXI_ADDR_WIDTH-1:MEM_AW+2];
  assign r_oob = |r_addr[C_S_AXI_ADDR_WIDTH-1:MEM_AW+2];
`else
  assign w_oob = 1'b0;
  assign r_oob = 1'b0;
`endif

  assign aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs        = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs        = S_AXI_RVALID && S_AXI_RREADY;
  assign w_at_len    = (w_cnt == w_len);
  assign w_last_beat = S_AXI_WLAST || w_at_len;
  assign w_mismatch  = (S_AXI_WLAST != w_at_len);
  assign r_at_len    = (r_cnt == r_len);

  // Keeps both address READYs low for the first cycle after reset release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next        = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = ready_en;
        if (ready_en && S_AXI_AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next        = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = ready_en;
        if (ready_en && S_AXI_ARVALID) r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_next = r_at_len ? R_IDLE : R_FETCH;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_fixed <= 1'b0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= S_AXI_AWID;
      w_addr  <= S_AXI_AWADDR;
      w_len   <= S_AXI_AWLEN;
      w_cnt   <= '0;
      w_fixed <= (S_AXI_AWBURST == 2'b00);
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      if (!w_fixed) w_addr <= w_addr + BEAT;
      if (w_mismatch || w_oob) w_err <= 1'b1;
    end
  end

  // RAM has no reset so its contents survive ARESET.
  always_ff @(posedge ACLK) begin
    if (w_hs && !w_oob) begin
      for (int b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++) begin
        if (S_AXI_WSTRB[b]) mem[w_addr[MEM_AW+1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
      r_last  <= 1'b0;
    end else if (ar_hs) begin
      r_id    <= S_AXI_ARID;
      r_addr  <= S_AXI_ARADDR;
      r_len   <= S_AXI_ARLEN;
      r_cnt   <= '0;
      r_fixed <= (S_AXI_ARBURST == 2'b00);
    end else if (r_state == R_FETCH) begin
      r_data <= r_oob ? '0 : mem[r_addr[MEM_AW+1:2]];
      r_resp <= r_oob ? RESP_SLVERR : RESP_OKAY;
      r_last <= r_at_len;
    end else if (r_hs && !r_at_len) begin
      r_cnt <= r_cnt + 8'd1;
      if (!r_fixed) r_addr <= r_addr + BEAT;
    end
  end

  assign S_AXI_BID   = w_id;
  assign S_AXI_BRESP = (w_state == W_RESP && w_err) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RID   = r_id;
  assign S_AXI_RDATA = r_data;
  assign S_AXI_RRESP = r_resp;
  assign S_AXI_RLAST = r_last;

endmodule

// File: tb/tb_zpaq_fxa_axi_slave_mem.sv
// Randomized bench for zpaq_fxa_axi_slave_mem against a word-array model with expected-beat queues.
module tb_zpaq_fxa_axi_slave_mem;
  localparam int MEM_AW = 10;

  logic        clk, rst;
  logic        awid, wlast, awvalid, awready, wvalid, wready, bid, bvalid, bready;
  logic        arid, arvalid, arready, rid, rlast, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;

  zpaq_fxa_axi_slave_mem #(.C_S_AXI_ID_WIDTH(1), .C_S_AXI_DATA_WIDTH(32),
                           .C_S_AXI_ADDR_WIDTH(32), .MEM_AW(MEM_AW)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        id;
  } rexp_t;

  int          checks = 0, errors = 0, cyc = 0;
  logic [31:0] model [2**MEM_AW];
  rexp_t       r_exp [$];
  logic [2:0]  b_exp [$];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  logic [31:0] cap_data [256];
  logic [1:0]  cap_resp [256];
  logic        cap_last [256];
  int          hs_cyc [256];
  logic        cap_id;
  logic [1:0]  last_bresp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit oob(input logic [31:0] a);
`ifdef ZPAQ_AXI_SLV_RANGE_CHK_EN
    return a >= 32'(1 << (MEM_AW + 2));
`else
    return a != a;
`endif
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] burst, input int k);
    return (burst == 2'd0) ? base : base + 32'(4 * k);
  endfunction

  // Compares the R and B channels against the expected queues whenever they are valid.
  initial begin
    logic        r_stall = 1'b0, b_stall = 1'b0;
    logic [35:0] r_hold = '0;
    logic [2:0]  b_hold = '0;
    rexp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_stall = 1'b0;
        b_stall = 1'b0;
      end else begin
        if (rvalid) begin
          if (r_exp.size() == 0) chk("r_unexpected", rvalid, 1'b0);
          else begin
            e = r_exp[0];
            chk("rdata", rdata, e.data);
            chk("rresp", rresp, e.resp);
            chk("rlast", rlast, e.last);
            chk("rid", rid, e.id);
            if (rready) void'(r_exp.pop_front());
          end
          if (r_stall) chk("r_stable", {rdata, rresp, rlast, rid}, r_hold);
        end else if (r_stall) chk("r_valid_held", rvalid, 1'b1);
        r_stall = rvalid && !rready;
        r_hold  = {rdata, rresp, rlast, rid};
        if (bvalid) begin
          if (b_exp.size() == 0) chk("b_unexpected", bvalid, 1'b0);
          else begin
            chk("b_id_resp", {bid, bresp}, b_exp[0]);
            if (bready) void'(b_exp.pop_front());
          end
          if (b_stall) chk("b_stable", {bid, bresp}, b_hold);
        end else if (b_stall) chk("b_valid_held", bvalid, 1'b1);
        b_stall = bvalid && !bready;
        b_hold  = {bid, bresp};
      end
    end
  end

  task automatic do_aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic id);
    int t = 0;
    awaddr = addr; awlen = len; awburst = burst; awid = id; awsize = 3'd2; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && t < 20) begin @(negedge clk); t++; end
    if (!awready) chk("aw_timeout", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic id, input int last_at, input int abort_at, input bit stall);
    int nb, t, d;
    logic err;
    logic [31:0] a;
    nb  = (last_at >= 0 && last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
    err = (last_at != int'(len));
    do_aw(addr, len, burst, id);
    for (int k = 0; k < nb; k++) begin
      a = beat_addr(addr, burst, k);
      wdata = wbuf[k]; wstrb = sbuf[k]; wlast = (k == last_at); wvalid = 1'b1;
      if (k == abort_at) begin
        #2 rst = 1'b1;
        #1 chk("rst_drop", {wready, bvalid, awready, arready, rvalid}, 5'b0);
        wvalid = 1'b0; wlast = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      chk("wready", wready, 1'b1);
      t = 0;
      while (!wready && t < 20) begin @(negedge clk); t++; end
      if (!wready) begin wvalid = 1'b0; return; end
      if (oob(a)) err = 1'b1;
      else for (int b = 0; b < 4; b++) if (sbuf[k][b]) model[a[MEM_AW+1:2]][8*b +: 8] = wbuf[k][8*b +: 8];
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    b_exp.push_back({id, err ? 2'b10 : 2'b00});
    @(negedge clk);
    chk("bvalid_lat", bvalid, 1'b1);
    @(posedge clk); #1;
    d = stall ? int'($urandom_range(0, 5)) : 0;
    repeat (d) begin @(posedge clk); #1; end
    bready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    if (!bvalid) chk("b_timeout", bvalid, 1'b1);
    else last_bresp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic id, input bit stall);
    int t, d;
    logic [31:0] a;
    rexp_t e;
    for (int k = 0; k <= int'(len); k++) begin
      a = beat_addr(addr, burst, k);
      e.data = oob(a) ? 32'h0 : model[a[MEM_AW+1:2]];
      e.resp = oob(a) ? 2'b10 : 2'b00;
      e.last = (k == int'(len));
      e.id   = id;
      r_exp.push_back(e);
    end
    araddr = addr; arlen = len; arburst = burst; arid = id; arsize = 3'd2; arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arready && t < 20) begin @(negedge clk); t++; end
    if (!arready) chk("ar_timeout", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid_lat1", rvalid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rvalid_lat2", rvalid, 1'b1);
    @(posedge clk); #1;
    for (int k = 0; k <= int'(len); k++) begin
      d = stall ? int'($urandom_range(0, 5)) : 0;
      if (d > 0) rready = 1'b0;
      repeat (d) begin @(posedge clk); #1; end
      rready = 1'b1;
      t = 0;
      @(negedge clk);
      while (!rvalid && t < 20) begin @(negedge clk); t++; end
      if (!rvalid) begin chk("r_timeout", rvalid, 1'b1); break; end
      cap_data[k] = rdata; cap_resp[k] = rresp; cap_last[k] = rlast; cap_id = rid; hs_cyc[k] = cyc;
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (!stall && len > 0) chk("r_rate", 64'(hs_cyc[len] - hs_cyc[0]), 64'(2 * int'(len)));
    chk("r_drain", 64'(r_exp.size()), 64'd0);
    r_exp.delete();
  endtask

  initial begin
    logic [31:0] addr, old2;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic        id;
    int          last_at;
    rst = 1'b1;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, rlast, bid, rid}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_pre", {awready, arready}, 2'b00);
    @(negedge clk);
    chk("ready_post", {awready, arready}, 2'b11);
    @(posedge clk); #1;

    // Fill the whole RAM so every model word is known.
    for (int blk = 0; blk < 4; blk++) begin
      for (int k = 0; k < 256; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'hF; end
      wr_burst(32'(blk * 1024), 8'd255, 2'd1, 1'b0, 255, -1, 1'b0);
    end

    for (int k = 0; k < 4; k++) begin wbuf[k] = 32'h11111111 * 32'(k + 1); sbuf[k] = 4'hF; end
    wr_burst(32'h40, 8'd3, 2'd1, 1'b0, 3, -1, 1'b0);
    chk("t1_bresp", last_bresp, 2'b00);
    chk("t1_model0", model[16], 32'h11111111);
    chk("t1_model3", model[19], 32'h44444444);
    rd_burst(32'h40, 8'd3, 2'd1, 1'b1, 1'b0);
    chk("t1_rdata0", cap_data[0], 32'h11111111);
    chk("t1_rdata3", cap_data[3], 32'h44444444);
    chk("t1_rlast", {cap_last[0], cap_last[1], cap_last[2], cap_last[3]}, 4'b0001);
    chk("t1_rid", cap_id, 1'b1);

    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
    wr_burst(32'h100, 8'd0, 2'd1, 1'b1, 0, -1, 1'b1);
    wbuf[0] = 32'h0000AA55; sbuf[0] = 4'b0011;
    wr_burst(32'h100, 8'd0, 2'd1, 1'b0, 0, -1, 1'b1);
    rd_burst(32'h100, 8'd0, 2'd1, 1'b0, 1'b0);
    chk("strb_rdata", cap_data[0], 32'hFFFFAA55);

    wbuf[0] = 32'hDEADBEEF; wbuf[1] = 32'hCAFEF00D; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    wr_burst(32'h180, 8'd1, 2'd1, 1'b1, 0, -1, 1'b0);
    chk("early_wlast_bresp", last_bresp, 2'b10);
    rd_burst(32'h180, 8'd1, 2'd1, 1'b1, 1'b0);
    chk("early_wlast_data0", cap_data[0], 32'hDEADBEEF);

    for (int k = 0; k < 8; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'hF; end
    wr_burst(32'h300, 8'd7, 2'd1, 1'b0, 7, -1, 1'b1);
    rd_burst(32'h300, 8'd7, 2'd1, 1'b1, 1'b1);

    old2 = model[(32'h200 >> 2) + 2];
    for (int k = 0; k < 4; k++) begin wbuf[k] = 32'hA0A0A0A0 + 32'(k); sbuf[k] = 4'hF; end
    wr_burst(32'h200, 8'd3, 2'd1, 1'b0, 3, 2, 1'b0);
    @(negedge clk);
    chk("rst_ready_pre", awready, 1'b0);
    @(negedge clk);
    chk("rst_ready_post", awready, 1'b1);
    @(posedge clk); #1;
    rd_burst(32'h200, 8'd3, 2'd1, 1'b1, 1'b0);
    chk("rst_keep0", cap_data[0], 32'hA0A0A0A0);
    chk("rst_keep1", cap_data[1], 32'hA0A0A0A1);
    chk("rst_skip2", cap_data[2], old2);
    for (int k = 0; k < 4; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'hF; end
    wr_burst(32'h200, 8'd3, 2'd1, 1'b1, 3, -1, 1'b1);
    chk("rst_new_bresp", last_bresp, 2'b00);
    rd_burst(32'h200, 8'd3, 2'd1, 1'b0, 1'b1);

    for (int k = 0; k < 4; k++) begin wbuf[k] = $urandom; sbuf[k] = 4'hF; end
    wr_burst(32'hFF8, 8'd3, 2'd2, 1'b0, 3, -1, 1'b0);
    rd_burst(32'hFF8, 8'd3, 2'd1, 1'b1, 1'b1);
    wbuf[0] = $urandom; wbuf[1] = $urandom; wbuf[2] = $urandom; sbuf[0] = 4'hF; sbuf[1] = 4'h6; sbuf[2] = 4'h9;
    wr_burst(32'h2F2, 8'd2, 2'd0, 1'b1, 2, -1, 1'b0);
    rd_burst(32'h2F0, 8'd1, 2'd0, 1'b0, 1'b0);

    for (int it = 0; it < 24; it++) begin
      addr  = 32'($urandom_range(0, 32'h1FFF));
      len   = 8'($urandom_range(0, 15));
      burst = 2'($urandom_range(0, 2));
      id    = 1'($urandom_range(0, 1));
      for (int k = 0; k <= int'(len); k++) begin wbuf[k] = $urandom; sbuf[k] = 4'($urandom); end
      last_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len) + 1)) - 1 : int'(len);
      wr_burst(addr, len, burst, id, last_at, -1, 1'($urandom_range(0, 1)));
      rd_burst(addr, len, burst, ~id, 1'($urandom_range(0, 1)));
      rd_burst(32'($urandom_range(0, 32'h1FFF)), 8'($urandom_range(0, 9)), 2'($urandom_range(0, 2)),
               id, 1'($urandom_range(0, 1)));
    end

`ifdef ZPAQ_AXI_SLV_RANGE_CHK_EN
    rd_burst(32'h1000, 8'd0, 2'd1, 1'b1, 1'b0);
    chk("oob_rresp", cap_resp[0], 2'b10);
    chk("oob_rdata", cap_data[0], 32'h0);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/zpaq_fxa_axi_slave_mem.md
# zpaq_fxa_axi_slave_mem

AXI4 memory-mapped slave responder with an internal word-addressed RAM. It is the target-side counterpart of the `M00_AXI` burst master in the zpaq_fxa_CC accelerator. It accepts write and read bursts, stores the data, and returns it, which allows the master to be closed-loop tested and used in hardware without an external memory model. Write and read channels run as independent state machines, each with one outstanding burst.

## Interface

Parameters:

- `C_S_AXI_ID_WIDTH`, 1: width of the ID fields.
- `C_S_AXI_DATA_WIDTH`, 32: data width. Fixed at 32.
- `C_S_AXI_ADDR_WIDTH`, 32: byte address width.
- `MEM_AW`, 10: log2 of the RAM depth in 32-bit words.

Ports:

- `ACLK` in 1: the single clock. Everything is rising-edge.
- `ARESET` in 1: reset, asynchronous and active-high.
- Write address channel:
  - `S_AXI_AWID` in ID; `S_AXI_AWADDR` in ADDR; `S_AXI_AWLEN` in 8; `S_AXI_AWSIZE` in 3; `S_AXI_AWBURST` in 2.
  - `S_AXI_AWVALID` in 1; `S_AXI_AWREADY` out 1.
- Write data channel:
  - `S_AXI_WDATA` in 32; `S_AXI_WSTRB` in 4; `S_AXI_WLAST` in 1.
  - `S_AXI_WVALID` in 1; `S_AXI_WREADY` out 1.
- Write response channel:
  - `S_AXI_BID` out ID; `S_AXI_BRESP` out 2.
  - `S_AXI_BVALID` out 1; `S_AXI_BREADY` in 1.
- Read address channel:
  - `S_AXI_ARID` in ID; `S_AXI_ARADDR` in ADDR; `S_AXI_ARLEN` in 8; `S_AXI_ARSIZE` in 3; `S_AXI_ARBURST` in 2.
  - `S_AXI_ARVALID` in 1; `S_AXI_ARREADY` out 1.
- Read data channel:
  - `S_AXI_RID` out ID; `S_AXI_RDATA` out 32; `S_AXI_RRESP` out 2; `S_AXI_RLAST` out 1.
  - `S_AXI_RVALID` out 1; `S_AXI_RREADY` in 1.

## Operation

- The RAM has `2**MEM_AW` words. The word index is `addr[MEM_AW+1:2]`.
  - Address bits [1:0] are ignored.
  - `AxSIZE` is ignored and is always treated as 4 bytes.
- Burst addressing:
  - FIXED (`AxBURST`=0): every beat uses the same address.
  - INCR (1) and WRAP (2): the address increments by 4 per beat. WRAP is treated as INCR.
  - The word index wraps modulo the RAM depth.
- Write FSM states: `W_IDLE` → `W_DATA` → `W_RESP`.
  - `W_IDLE`: `AWREADY`=1. On the AW handshake, latch ID, address, LEN and BURST, clear the beat counter, and go to `W_DATA`.
  - `W_DATA`: `WREADY`=1. Each W handshake writes the bytes enabled by `WSTRB` and increments the counter.
    - The burst ends on the beat where `WLAST`=1 or the counter equals `AWLEN`, whichever comes first. Then go to `W_RESP`.
    - If `WLAST` does not match the counter, set a sticky `SLVERR` for this burst.
  - `W_RESP`: `BVALID`=1, `BID` is the latched ID, `BRESP` is `OKAY` or `SLVERR`. On `BREADY`, return to `W_IDLE`.
- Read FSM states: `R_IDLE` → `R_FETCH` → `R_DATA`.
  - `R_IDLE`: `ARREADY`=1. On the AR handshake, latch the request and go to `R_FETCH`.
  - `R_FETCH`: synchronous RAM read, one cycle, then go to `R_DATA`.
  - `R_DATA`: `RVALID`=1. `RDATA`, `RID`, `RRESP` and `RLAST` stay stable until `RREADY`. On the handshake:
    - if it was the last beat (counter equals `ARLEN`), go to `R_IDLE`;
    - otherwise advance the address and go to `R_FETCH`.
- Write and read use separate RAM ports. On the same word in the same cycle, the read returns the old data (read-first).

## Timing

- Reset values:
  - all `VALID` and `READY` outputs are 0;
  - `BRESP`, `RRESP`, `RDATA`, `RLAST`, `BID` and `RID` are 0.
  - `AWREADY` and `ARREADY` rise on the first clock edge after `ARESET` deasserts.
- Write timing:
  - AW handshake at edge N → `WREADY`=1 from N+1.
  - W beats are accepted one per cycle.
  - Last W beat at edge M → `BVALID`=1 from M+1.
- Read timing:
  - AR handshake at edge N → `RVALID` from N+2.
  - Sustained rate is one beat per two cycles when `RREADY` is held high.
- `AWREADY`=0 while the write FSM is not in `W_IDLE`; `ARREADY`=0 while the read FSM is not in `R_IDLE`.
- `ARESET` asserted mid-burst returns both FSMs to idle and drops every `VALID` and `READY` immediately. RAM contents are preserved.

## Configuration

- `ZPAQ_AXI_SLV_RANGE_CHK_EN` defined:
  - Any beat whose byte address is at or above `2**(MEM_AW+2)` is not written.
  - That write burst responds `SLVERR`.
  - Such read beats return `RDATA`=0 with `RRESP`=`SLVERR`.
- `ZPAQ_AXI_SLV_RANGE_CHK_EN` undefined: the address wraps modulo the RAM depth, and responses are `OKAY` except for the `WLAST` mismatch.

## Test plan

- Write one INCR burst: AWADDR=0x40, AWLEN=3, data 0x11111111..0x44444444. Then read one INCR burst: ARADDR=0x40, ARLEN=3. Required: `BRESP`=`OKAY`, `RDATA` matches, `RLAST` only on beat 4, `RID`=`ARID`.
- Write 0xFFFFFFFF, then write 0x0000AA55 with `WSTRB`=4'b0011 to the same word. Required read-back: 0xFFFFAA55.
- Write with AWLEN=1 and `WLAST` asserted on beat 0. Required: `BVALID` after that beat with `BRESP`=`SLVERR`.
- Random `RREADY` and `BREADY` stalls of 0-5 cycles on an ARLEN=7 burst. Required: outputs stable while stalled and 8 beats delivered in order.
- Assert `ARESET` during beat 2 of a 4-beat write. Required: `WREADY` and `BVALID` are 0 immediately, beats 0-1 persist on read-back, and a new burst completes normally.
- With `ZPAQ_AXI_SLV_RANGE_CHK_EN` defined and MEM_AW=10, read ARADDR=0x1000. Required: `RRESP`=`SLVERR` and `RDATA`=0.
